// File: rtl/wave_pkg.sv
// Shared constants and types for the wave_player playback engine.
// Defaults here size the top; PIPE_LAT is the read-to-DAC latency.
package wave_pkg;
  localparam int BUFFER_LEN = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 8;
  localparam int PHASE_W = ADDR_W + FRAC_W;
  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DRAIN
  } state_e;
endpackage

// File: rtl/wave_bank_ram.sv
// Two ping-pong sample banks: one write port, one registered read port.
// Bank select is the address MSB so the pair maps onto a single SDPB.
module wave_bank_ram #(
  parameter int BUFFER_LEN = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] mem_q [2*BUFFER_LEN];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    rd_q <= mem_q[{i_rd_bank, i_rd_addr}];
  end

  assign o_rd_data = rd_q;
endmodule

// File: rtl/wave_player.sv
// Arbitrary-waveform player: phase accumulator over a ping-pong bank RAM.
// Build option WAVE_IDLE_MIDSCALE_EN parks o_dac_data at midscale when idle.
module wave_player #(
  parameter int BUFFER_LEN = wave_pkg::BUFFER_LEN,
  parameter int ADDR_W = wave_pkg::ADDR_W,
  parameter int DATA_W = wave_pkg::DATA_W,
  parameter int FRAC_W = wave_pkg::FRAC_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_single,
  input  logic [ADDR_W+FRAC_W-1:0] i_step,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_swap,
  output logic                     o_swap_ack,
  output logic                     o_bank,
  output logic [DATA_W-1:0]        o_dac_data,
  output logic                     o_dac_valid
);
  import wave_pkg::*;

  localparam int PW = ADDR_W + FRAC_W;
`ifdef WAVE_IDLE_MIDSCALE_EN
  localparam logic [DATA_W-1:0] IDLE_V = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] IDLE_V = '0;
`endif

  state_e            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     step_q, step_d;
  logic              single_q, single_d;
  logic              bank_q, bank_d;
  logic              pend_q, pend_d;
  logic              comp_q, comp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              v1_q, v1_d;
  logic              dval_q, dval_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic [PW:0]       sum;
  logic [DATA_W-1:0] rd_data;

  wave_bank_ram #(
    .BUFFER_LEN(BUFFER_LEN),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_ram (
    .i_clk    (i_clk),
    .i_wr_en  (i_wr_en),
    .i_wr_bank(~bank_q),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .i_rd_bank(bank_q),
    .i_rd_addr(phase_q[PW-1:FRAC_W]),
    .o_rd_data(rd_data)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    single_d = single_q;
    bank_d   = bank_q;
    pend_d   = pend_q;
    comp_d   = comp_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ack_d    = 1'b0;
    sum      = {1'b0, phase_q} + {1'b0, step_q};
    v1_d     = (state_q == PLAY);
    dval_d   = v1_q;
    case (state_q)
      IDLE: begin
        if (i_swap) begin
          bank_d = ~bank_q;
          ack_d  = 1'b1;
        end
        if (i_start && (|i_step)) begin
          state_d  = PLAY;
          step_d   = i_step;
          single_d = i_single;
          phase_d  = '0;
        end
      end
      PLAY: begin
        phase_d = sum[PW-1:0];
        if (i_swap) pend_d = 1'b1;
        // Stop takes priority over a single-pass wrap: no done.
        if (i_stop || (single_q && sum[PW])) begin
          state_d = DRAIN;
          cnt_d   = '0;
          comp_d  = ~i_stop;
        end else if (sum[PW] && pend_q) begin
          bank_d = ~bank_q;
          ack_d  = 1'b1;
          pend_d = 1'b0;
        end
      end
      DRAIN: begin
        if (i_swap) pend_d = 1'b1;
        if (cnt_q == 2'(PIPE_LAT - 1)) begin
          state_d = IDLE;
          done_d  = comp_q;
          comp_d  = 1'b0;
          if (pend_q || i_swap) begin
            bank_d = ~bank_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ddata_d = ddata_q;
    if (v1_q) begin
      ddata_d = rd_data;
    end
`ifdef WAVE_IDLE_MIDSCALE_EN
    else if (state_d == IDLE) begin
      ddata_d = IDLE_V;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      step_q   <= '0;
      single_q <= 1'b0;
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
      comp_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      v1_q     <= 1'b0;
      dval_q   <= 1'b0;
      ddata_q  <= IDLE_V;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      single_q <= single_d;
      bank_q   <= bank_d;
      pend_q   <= pend_d;
      comp_q   <= comp_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      v1_q     <= v1_d;
      dval_q   <= dval_d;
      ddata_q  <= ddata_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_swap_ack  = ack_q;
  assign o_bank      = bank_q;
  assign o_dac_data  = ddata_q;
  assign o_dac_valid = dval_q;
endmodule

// File: tb/tb_wave_player.sv
// Scoreboard bench for wave_player: stimulus pushes expected samples,
// a negedge monitor pops them as o_dac_valid presents each one.
module tb_wave_player;
  localparam int TOT = 131072;
`ifdef WAVE_IDLE_MIDSCALE_EN
  localparam logic [7:0] IDLE_V = 8'h80;
`else
  localparam logic [7:0] IDLE_V = 8'h00;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_single = 1'b0;
  logic [16:0] i_step = '0;
  logic        o_busy;
  logic        o_done;
  logic        i_wr_en = 1'b0;
  logic [8:0]  i_wr_addr = '0;
  logic [7:0]  i_wr_data = '0;
  logic        i_swap = 1'b0;
  logic        o_swap_ack;
  logic        o_bank;
  logic [7:0]  o_dac_data;
  logic        o_dac_valid;

  wave_player dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_single   (i_single),
    .i_step     (i_step),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_swap     (i_swap),
    .o_swap_ack (o_swap_ack),
    .o_bank     (o_bank),
    .o_dac_data (o_dac_data),
    .o_dac_valid(o_dac_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int k;
    int a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem [2][512];
  logic [7:0] exp_q [$];
  wr_t        wq [$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         nval, nack, ndone, first_cyc, last_cyc;
  bit         ign = 1'b0;
  bit         prev_busy = 1'b0;
  bit         model_bank = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge i_clk);
      if (o_dac_valid && !ign) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_sample actual=%0h required=none", o_dac_data);
        end else begin
          e = exp_q.pop_front();
          chk("sample", o_dac_data, e);
          nval++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
      if (o_swap_ack) nack++;
      if (o_done) begin
        ndone++;
        chk("done_with_busy_fall", {prev_busy, o_busy}, 2'b10);
      end
      prev_busy = o_busy;
    end
  end

  task automatic load(input bit rnd);
    logic [7:0] d;
    for (int a = 0; a < 512; a++) begin
      @(negedge i_clk);
      d = rnd ? 8'($urandom) : 8'(a);
      i_wr_en = 1'b1;
      i_wr_addr = 9'(a);
      i_wr_data = d;
      mem[~model_bank][a] = d;
    end
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic idle_swap();
    @(negedge i_clk);
    i_swap = 1'b1;
    @(negedge i_clk);
    i_swap = 1'b0;
    model_bank = ~model_bank;
    chk("idle_swap_ack", o_swap_ack, 1);
    chk("idle_swap_bank", o_bank, model_bank);
  endtask

  // Issue k reads address floor((k*step mod 2^17)/256); a pending swap
  // takes effect from the first issue of the next pass in continuous mode.
  task automatic run(input int s, input bit single, input int stop_j,
                     input int swap_q);
    int n, last, spass, pass, a, start_cyc;
    bit b, bk, exp_done;
    logic [7:0] last_exp;
    wr_t wr;
    @(posedge i_clk);
    #1;
    nval = 0; nack = 0; ndone = 0; first_cyc = -1; last_cyc = -1;
    b = model_bank;
    n = single ? (TOT + s - 1) / s : 1 << 30;
    last = n - 1;
    if (stop_j >= 0 && stop_j < last) last = stop_j;
    exp_done = single && (stop_j < 0 || stop_j > n - 1);
    spass = (swap_q >= 0) ? (swap_q * s) / TOT : 0;
    last_exp = '0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_step = 17'(s);
    i_single = single;
    @(negedge i_clk);
    i_start = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k <= last; k++) begin
      pass = (k * s) / TOT;
      a = ((k * s) % TOT) / 256;
      bk = (!single && swap_q >= 0 && pass > spass) ? ~b : b;
      last_exp = mem[bk][a];
      exp_q.push_back(last_exp);
      i_stop = (k == stop_j);
      i_swap = (k == swap_q);
      if (wq.size() > 0 && wq[0].k == k) begin
        wr = wq.pop_front();
        i_wr_en = 1'b1;
        i_wr_addr = 9'(wr.a);
        i_wr_data = wr.d;
        mem[~bk][wr.a] = wr.d;
      end
      @(negedge i_clk);
      i_stop = 1'b0;
      i_swap = 1'b0;
      i_wr_en = 1'b0;
    end
    if (swap_q >= 0) model_bank = ~b;
    for (int i = 0; i < 8 && o_busy; i++) @(negedge i_clk);
    chk("busy_fall", o_busy, 0);
`ifdef WAVE_IDLE_MIDSCALE_EN
    chk("idle_data", o_dac_data, IDLE_V);
`else
    chk("idle_data_hold", o_dac_data, last_exp);
`endif
    @(posedge i_clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("n_valid", nval, last + 1);
    chk("first_latency", first_cyc - start_cyc, 2);
    chk("no_gap", last_cyc - first_cyc + 1, nval);
    chk("done_count", ndone, int'(exp_done));
    chk("ack_count", nack, int'(swap_q >= 0));
    chk("bank_after", o_bank, model_bank);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_ack"}, o_swap_ack, 0);
    chk({tag, "_bank"}, o_bank, 0);
    chk({tag, "_valid"}, o_dac_valid, 0);
    chk({tag, "_data"}, o_dac_data, IDLE_V);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    wr_t w;
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_state("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    load(1'b0);
    idle_swap();
    load(1'b1);
    run(32'h100, 1'b1, -1, -1);
    run(32'h080, 1'b0, 1100, -1);
    run(32'h100, 1'b1, 102, 20);

    @(negedge i_clk);
    i_start = 1'b1;
    i_step = '0;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("step0_busy", o_busy, 0);
    chk("step0_valid", o_dac_valid, 0);

    run(int'($urandom_range(32'h40, 32'h300)), 1'b1, -1, -1);

    w.k = 50;  w.a = 0;  w.d = 8'($urandom); wq.push_back(w);
    w.k = 550; w.a = 88; w.d = 8'($urandom); wq.push_back(w);
    run(32'h100, 1'b0, 700, 200);

    ign = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1;
    i_step = 17'h100;
    i_single = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (40) @(negedge i_clk);
    i_swap = 1'b1;
    @(negedge i_clk);
    i_swap = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk_reset_state("async_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    ign = 1'b0;
    model_bank = 1'b0;
    run(32'h100, 1'b1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wave_player.md
Name: wave_player

Overview:
- Arbitrary-waveform playback engine, the transmit counterpart of the scope capture path.
- Streams 8-bit samples from a ping-pong sample buffer to a DAC at one sample per clock.
- Playback address comes from a fractional phase accumulator, so the effective frequency is programmable.
- Uses the same start/stop/busy/done handshake as the capture controller; a loader writes the idle bank while the other bank plays.

Parameters:
- BUFFER_LEN, 512: samples per bank; power of two.
- ADDR_W, 9: log2(BUFFER_LEN).
- DATA_W, 8: sample width.
- FRAC_W, 8: fractional bits of the phase accumulator.

Ports:
- i_clk  in  1  single clock; all logic on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start request, level-sampled.
- i_stop  in  1  stop request.
- i_single  in  1  mode, latched at start: 1 = one pass, 0 = continuous.
- i_step  in  ADDR_W+FRAC_W  phase increment, latched at start; 0x100 = 1 sample/clk at FRAC_W=8.
- o_busy  out  1  high in PLAY and DRAIN.
- o_done  out  1  one-cycle pulse on single-pass completion.
- i_wr_en  in  1  loader write strobe.
- i_wr_addr  in  ADDR_W  loader address.
- i_wr_data  in  DATA_W  loader data.
- i_swap  in  1  bank swap request pulse.
- o_swap_ack  out  1  one-cycle pulse when the swap is applied.
- o_bank  out  1  bank currently played.
- o_dac_data  out  DATA_W  registered DAC sample.
- o_dac_valid  out  1  high when o_dac_data holds a new sample.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_swap_ack=0, o_bank=0, o_dac_valid=0, o_dac_data=0x00, phase=0, swap_pending=0, state=IDLE.
- Bank RAM contents are not reset.
- IDLE:
  - i_start=1 with i_step!=0 → PLAY; latch i_step and i_single; phase=0.
  - Start with i_step=0 is ignored.
  - i_stop has no effect in IDLE.
- PLAY:
  - Each cycle, read address = phase[ADDR_W+FRAC_W-1:FRAC_W] in bank o_bank.
  - phase <= phase + step, modulo 2^(ADDR_W+FRAC_W); carry out = wrap.
  - i_start is ignored.
- Pipeline: address issue → RAM registered read (cycle+1) → o_dac_data register (cycle+2).
  - o_dac_valid is high exactly for samples issued in PLAY, delayed by 2 cycles.
- Single mode: on the cycle the phase add carries out, that address is the last one issued. Then → DRAIN.
- Continuous mode: a wrap continues playback from the wrapped phase; the fractional part is preserved.
- i_stop in PLAY: the current address is the last one issued → DRAIN. No o_done is generated.
- If i_stop and a single-mode wrap occur in the same cycle, stop wins: no o_done.
- DRAIN: lasts 2 cycles so the pipeline empties, then → IDLE with o_busy=0.
  - o_done pulses in the same cycle o_busy falls, single completion only.
- Writes: i_wr_en writes to bank !o_bank, using o_bank as it was before any same-cycle swap. Writes never touch the playing bank.
- Swap:
  - i_swap in IDLE toggles o_bank next cycle and pulses o_swap_ack.
  - i_swap in PLAY/DRAIN sets swap_pending. The swap is applied on the next phase wrap in continuous PLAY, or on entry to IDLE otherwise. The address issued in the wrap cycle already uses the new bank. o_swap_ack pulses when applied.
  - Repeated i_swap while pending has no further effect.
- Reset mid-playback: all of the above return to reset values immediately; any pending swap is dropped.
- Output hold: o_dac_data holds its last sample when o_dac_valid=0.

Optional Feature:
- WAVE_IDLE_MIDSCALE_EN
  - Defined: the reset value and the IDLE value of o_dac_data are 1<<(DATA_W-1) (0x80). o_dac_data goes to midscale on the cycle after DRAIN ends.
  - Undefined: reset value 0x00; the last sample is held in IDLE.

Decomposition:
- Shared package wave_pkg holds:
  - state enum: IDLE, PLAY, DRAIN
  - PIPE_LAT=2
  - phase width constant ADDR_W+FRAC_W
- Sub-module wave_bank_ram: two BUFFER_LEN×DATA_W banks with one write port (bank select, address, data) and one registered read port (bank select, address). Maps to the vendor SDPB.

Test Plan:
- Load bank1 with ramp 0..255,0..255, swap in IDLE, start single with step=0x100:
  - o_swap_ack pulses; o_bank=1.
  - 512 valid samples 0..255,0..255; first valid sample 2 cycles after start is accepted.
  - o_done pulses once as o_busy falls.
- Continuous, step=0x080: each sample is output twice; sample index wraps 511→0 with no gap in o_dac_valid.
- Continuous playing bank0; write bank1; pulse i_swap mid-buffer:
  - no change until the wrap;
  - the wrap cycle reads bank1 address 0; o_swap_ack pulses once.
  - A write to the playing bank's address during play is not observed.
- Stop mid-single at sample 100: exactly 2 further valid samples; o_busy falls; no o_done. Start with step=0 → ignored, o_busy stays 0.
- Assert i_rst during PLAY: all outputs go to reset values asynchronously; the next start replays from address 0 of bank 0.
- With WAVE_IDLE_MIDSCALE_EN: o_dac_data=0x80 after reset and 1 cycle after DRAIN. Without it: 0x00 after reset and the last sample is held.
